// File: rtl/ir_pkg.sv
// Shared opcode map, fetch FSM states and operand-presence rule for the
// instruction register and the future control unit.
package ir_pkg;

  localparam logic [7:0] OPC_LD   = 8'hFF;
  localparam logic [7:0] OPC_ADD  = 8'hFE;
  localparam logic [7:0] OPC_SUB  = 8'hFD;
  localparam logic [7:0] OPC_AND  = 8'hFC;
  localparam logic [7:0] OPC_OR   = 8'hFB;
  localparam logic [7:0] OPC_SHL  = 8'hF9;
  localparam logic [7:0] OPC_HALT = 8'hF8;
  localparam logic [7:0] OPC_XOR  = 8'hF2;

  typedef enum logic [1:0] {
    S_OPC  = 2'd0,
    S_OPND = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;

  function automatic logic has_operand(input logic [7:0] opc);
    return opc inside {OPC_LD, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR};
  endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational opcode to one-hot decoder; any nonzero bit above the 8-bit
// opcode field, or an unlisted value, decodes as ILLEGAL.
module ir_decode
  import ir_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_opcode,
  input  logic              i_en,
  output logic              o_ld,
  output logic              o_add,
  output logic              o_sub,
  output logic              o_and,
  output logic              o_or,
  output logic              o_shl,
  output logic              o_xor,
  output logic              o_halt,
  output logic              o_illegal
);

  logic w_hi_zero;

  assign w_hi_zero = ((i_opcode >> 8) == '0);

  always_comb begin
    o_ld      = 1'b0;
    o_add     = 1'b0;
    o_sub     = 1'b0;
    o_and     = 1'b0;
    o_or      = 1'b0;
    o_shl     = 1'b0;
    o_xor     = 1'b0;
    o_halt    = 1'b0;
    o_illegal = 1'b0;
    if (i_en) begin
      if (!w_hi_zero) begin
        o_illegal = 1'b1;
      end else begin
        case (i_opcode[7:0])
          OPC_LD:   o_ld      = 1'b1;
          OPC_ADD:  o_add     = 1'b1;
          OPC_SUB:  o_sub     = 1'b1;
          OPC_AND:  o_and     = 1'b1;
          OPC_OR:   o_or      = 1'b1;
          OPC_SHL:  o_shl     = 1'b1;
          OPC_XOR:  o_xor     = 1'b1;
          OPC_HALT: o_halt    = 1'b1;
          default:  o_illegal = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/ir_fetch_decode.sv
// Instruction register: fetches an opcode plus 0 or OPND_BYTES operand bytes
// over valid/ready, presents the decoded instruction until ACK, halts on HALT.
module ir_fetch_decode
  import ir_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OPND_BYTES = 1
) (
  input  logic                         i_clk,
  input  logic                         i_clr_n,
  input  logic [DATA_W-1:0]            i_d,
  input  logic                         i_d_valid,
  output logic                         o_d_ready,
  input  logic                         i_instr_ack,
  input  logic                         i_resume,
  output logic                         o_instr_valid,
  output logic                         o_ld,
  output logic                         o_add,
  output logic                         o_sub,
  output logic                         o_and,
  output logic                         o_or,
  output logic                         o_shl,
  output logic                         o_xor,
  output logic                         o_halt,
  output logic                         o_illegal,
  output logic [DATA_W-1:0]            o_opcode,
  output logic [OPND_BYTES*DATA_W-1:0] o_operand,
  output logic                         o_halted
);

  localparam int CNT_W = (OPND_BYTES > 1) ? $clog2(OPND_BYTES) : 1;

  state_e                        r_state;
  state_e                        w_state_nxt;
  logic                          r_live;
  logic [DATA_W-1:0]             r_opcode;
  logic [OPND_BYTES*DATA_W-1:0]  r_operand;
  logic [CNT_W-1:0]              r_cnt;
  logic                          w_xfer;
  logic                          w_has_opnd;
  logic                          w_opc_is_halt;

  // Upper data bits force ILLEGAL, so such opcodes never fetch operands.
  assign w_has_opnd    = has_operand(i_d[7:0]) && ((i_d >> 8) == '0);
  assign w_opc_is_halt = (r_opcode == DATA_W'(OPC_HALT));
  assign w_xfer        = i_d_valid & o_d_ready;

  always_comb begin
    w_state_nxt   = r_state;
    o_d_ready     = 1'b0;
    o_instr_valid = 1'b0;
    o_halted      = 1'b0;
    case (r_state)
      S_OPC: begin
        o_d_ready = r_live;
        if (r_live && i_d_valid) w_state_nxt = w_has_opnd ? S_OPND : S_HOLD;
      end
      S_OPND: begin
        o_d_ready = r_live;
        if (r_live && i_d_valid && (r_cnt == CNT_W'(OPND_BYTES - 1))) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        o_instr_valid = 1'b1;
        if (i_instr_ack) w_state_nxt = w_opc_is_halt ? S_HALT : S_OPC;
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (i_resume) w_state_nxt = S_OPC;
      end
      default: w_state_nxt = S_OPC;
    endcase
  end

  // r_live keeps D_READY low until the first clock after reset release.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state   <= S_OPC;
      r_live    <= 1'b0;
      r_opcode  <= '0;
      r_operand <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_xfer) begin
        if (r_state == S_OPC) begin
          r_opcode  <= i_d;
          r_operand <= '0;
          r_cnt     <= '0;
        end else begin
          for (int i = 0; i < OPND_BYTES; i++) begin
            if (r_cnt == CNT_W'(i)) r_operand[i*DATA_W +: DATA_W] <= i_d;
          end
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_opcode  = r_opcode;
  assign o_operand = r_operand;

  ir_decode #(.DATA_W(DATA_W)) u_dec (
    .i_opcode  (r_opcode),
    .i_en      (o_instr_valid),
    .o_ld      (o_ld),
    .o_add     (o_add),
    .o_sub     (o_sub),
    .o_and     (o_and),
    .o_or      (o_or),
    .o_shl     (o_shl),
    .o_xor     (o_xor),
    .o_halt    (o_halt),
    .o_illegal (o_illegal)
  );

endmodule

// File: tb/tb_ir_fetch_decode.sv
// Bench for ir_fetch_decode: directed table on a 1-operand-byte instance, a
// 2-byte LD sequence, and random traffic checked against a queue-level model.
module tb_ir_fetch_decode;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [7:0] d = 8'h00;
  logic       dv = 1'b0;
  logic       ack = 1'b0;
  logic       res = 1'b0;

  logic        rdy_a, val_a, hlt_a, rdy_b, val_b, hlt_b;
  logic [8:0]  dec_a, dec_b;
  logic [7:0]  opc_a, opc_b, opnd_a;
  logic [15:0] opnd_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ir_fetch_decode #(.DATA_W(8), .OPND_BYTES(1)) dut_a (
    .i_clk(clk), .i_clr_n(clr_n), .i_d(d), .i_d_valid(dv), .o_d_ready(rdy_a),
    .i_instr_ack(ack), .i_resume(res), .o_instr_valid(val_a),
    .o_ld(dec_a[8]), .o_add(dec_a[7]), .o_sub(dec_a[6]), .o_and(dec_a[5]),
    .o_or(dec_a[4]), .o_shl(dec_a[3]), .o_xor(dec_a[2]), .o_halt(dec_a[1]),
    .o_illegal(dec_a[0]), .o_opcode(opc_a), .o_operand(opnd_a), .o_halted(hlt_a)
  );

  ir_fetch_decode #(.DATA_W(8), .OPND_BYTES(2)) dut_b (
    .i_clk(clk), .i_clr_n(clr_n), .i_d(d), .i_d_valid(dv), .o_d_ready(rdy_b),
    .i_instr_ack(ack), .i_resume(res), .o_instr_valid(val_b),
    .o_ld(dec_b[8]), .o_add(dec_b[7]), .o_sub(dec_b[6]), .o_and(dec_b[5]),
    .o_or(dec_b[4]), .o_shl(dec_b[3]), .o_xor(dec_b[2]), .o_halt(dec_b[1]),
    .o_illegal(dec_b[0]), .o_opcode(opc_b), .o_operand(opnd_b), .o_halted(hlt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: bytes taken are opcode then owed operand bytes; decode by lookup.
  function automatic logic [8:0] ref_dec(input logic [7:0] o);
    case (o)
      8'hFF: return 9'h100;
      8'hFE: return 9'h080;
      8'hFD: return 9'h040;
      8'hFC: return 9'h020;
      8'hFB: return 9'h010;
      8'hF9: return 9'h008;
      8'hF2: return 9'h004;
      8'hF8: return 9'h002;
      default: return 9'h001;
    endcase
  endfunction

  function automatic logic ref_has(input logic [7:0] o);
    return (o == 8'hFF) || (o == 8'hFE) || (o == 8'hFD) || (o == 8'hFC) ||
           (o == 8'hFB) || (o == 8'hF2);
  endfunction

  int          nb   [2] = '{1, 2};
  logic        m_live [2];
  logic        m_pres [2];
  logic        m_halt [2];
  logic [7:0]  m_opc  [2];
  logic [15:0] m_opnd [2];
  int          m_left [2];
  int          m_pos  [2];

  task automatic mreset(input int k);
    m_live[k] = 1'b0; m_pres[k] = 1'b0; m_halt[k] = 1'b0;
    m_opc[k] = 8'h00; m_opnd[k] = 16'h0000; m_left[k] = 0; m_pos[k] = 0;
  endtask

  initial begin
    mreset(0);
    mreset(1);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!clr_n) begin
        mreset(k);
      end else begin
        if (m_pres[k]) begin
          if (ack) begin
            m_pres[k] = 1'b0;
            if (m_opc[k] == 8'hF8) m_halt[k] = 1'b1;
          end
        end else if (m_halt[k]) begin
          if (res) m_halt[k] = 1'b0;
        end else if (m_live[k] && dv) begin
          if (m_left[k] == 0) begin
            m_opc[k]  = d;
            m_opnd[k] = 16'h0000;
            m_pos[k]  = 0;
            m_left[k] = ref_has(d) ? nb[k] : 0;
            if (m_left[k] == 0) m_pres[k] = 1'b1;
          end else begin
            m_opnd[k] = m_opnd[k] | (16'(d) << (8 * m_pos[k]));
            m_pos[k]++;
            m_left[k]--;
            if (m_left[k] == 0) m_pres[k] = 1'b1;
          end
        end
        m_live[k] = 1'b1;
      end
    end
  end

  task automatic cmp_dut(input int k, input logic r, input logic v, input logic h,
                         input logic [8:0] dc, input logic [7:0] oc, input logic [15:0] op);
    chk($sformatf("model u%0d ready", k), 32'(r), 32'(m_live[k] && !m_pres[k] && !m_halt[k]));
    chk($sformatf("model u%0d valid", k), 32'(v), 32'(m_pres[k]));
    chk($sformatf("model u%0d halted", k), 32'(h), 32'(m_halt[k]));
    chk($sformatf("model u%0d decode", k), 32'(dc), 32'(m_pres[k] ? ref_dec(m_opc[k]) : 9'h000));
    chk($sformatf("model u%0d opcode", k), 32'(oc), 32'(m_opc[k]));
    chk($sformatf("model u%0d operand", k), 32'(op), 32'(m_opnd[k]));
  endtask

  always @(negedge clk) begin
    if (!clr_n) begin
      mreset(0);
      mreset(1);
    end
    cmp_dut(0, rdy_a, val_a, hlt_a, dec_a, opc_a, {8'h00, opnd_a});
    cmp_dut(1, rdy_b, val_b, hlt_b, dec_b, opc_b, opnd_b);
  end

  typedef struct {
    logic       clr_n, dv;
    logic [7:0] d;
    logic       ack, res, e_rdy, e_val;
    logic [8:0] e_dec;
    logic [7:0] e_opc, e_opnd;
    logic       e_hlt;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic c, input logic vl, input logic [7:0] dd, input logic a,
                   input logic r, input logic er, input logic ev, input logic [8:0] ed,
                   input logic [7:0] eo, input logic [7:0] eop, input logic eh);
    vec_t t;
    t.clr_n = c; t.dv = vl; t.d = dd; t.ack = a; t.res = r;
    t.e_rdy = er; t.e_val = ev; t.e_dec = ed; t.e_opc = eo; t.e_opnd = eop; t.e_hlt = eh;
    tbl.push_back(t);
  endtask

  logic [7:0] ops [9] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hF9, 8'hF8, 8'hF2, 8'h00};

  initial begin
    // Each row: inputs for this cycle; expected outputs seen during this cycle.
    //  clr dv  d      ack res  rdy val dec     opc    opnd   hlt
    v(0, 1, 8'hFE, 0, 0,  0, 0, 9'h000, 8'h00, 8'h00, 0);
    v(0, 1, 8'hFE, 0, 0,  0, 0, 9'h000, 8'h00, 8'h00, 0);
    v(1, 0, 8'hFE, 0, 0,  0, 0, 9'h000, 8'h00, 8'h00, 0);
    v(1, 1, 8'hFE, 0, 0,  1, 0, 9'h000, 8'h00, 8'h00, 0);
    v(1, 1, 8'h3C, 0, 1,  1, 0, 9'h000, 8'hFE, 8'h00, 0);
    for (int i = 0; i < 5; i++)
      v(1, 0, 8'h00, 0, 0,  0, 1, 9'h080, 8'hFE, 8'h3C, 0);
    v(1, 0, 8'h00, 1, 0,  0, 1, 9'h080, 8'hFE, 8'h3C, 0);
    v(1, 1, 8'hF9, 0, 0,  1, 0, 9'h000, 8'hFE, 8'h3C, 0);
    v(1, 1, 8'h00, 0, 0,  0, 1, 9'h008, 8'hF9, 8'h00, 0);
    v(1, 1, 8'h00, 1, 0,  0, 1, 9'h008, 8'hF9, 8'h00, 0);
    v(1, 1, 8'h00, 0, 0,  1, 0, 9'h000, 8'hF9, 8'h00, 0);
    v(1, 0, 8'h00, 0, 0,  0, 1, 9'h001, 8'h00, 8'h00, 0);
    v(1, 0, 8'h00, 1, 0,  0, 1, 9'h001, 8'h00, 8'h00, 0);
    v(1, 1, 8'hF8, 0, 0,  1, 0, 9'h000, 8'h00, 8'h00, 0);
    v(1, 1, 8'hFE, 0, 0,  0, 1, 9'h002, 8'hF8, 8'h00, 0);
    v(1, 1, 8'hFE, 1, 0,  0, 1, 9'h002, 8'hF8, 8'h00, 0);
    v(1, 1, 8'hFE, 0, 0,  0, 0, 9'h000, 8'hF8, 8'h00, 1);
    v(1, 1, 8'hFE, 1, 1,  0, 0, 9'h000, 8'hF8, 8'h00, 1);
    v(1, 1, 8'hFE, 0, 0,  1, 0, 9'h000, 8'hF8, 8'h00, 0);
    v(1, 1, 8'h11, 0, 0,  1, 0, 9'h000, 8'hFE, 8'h00, 0);
    v(1, 0, 8'h00, 0, 0,  0, 1, 9'h080, 8'hFE, 8'h11, 0);
    v(1, 0, 8'h00, 1, 0,  0, 1, 9'h080, 8'hFE, 8'h11, 0);
    v(1, 1, 8'hFD, 0, 0,  1, 0, 9'h000, 8'hFE, 8'h11, 0);
    v(0, 0, 8'h00, 0, 0,  0, 0, 9'h000, 8'h00, 8'h00, 0);
    v(1, 0, 8'h00, 0, 0,  0, 0, 9'h000, 8'h00, 8'h00, 0);
    v(1, 1, 8'hFC, 0, 0,  1, 0, 9'h000, 8'h00, 8'h00, 0);
    v(1, 1, 8'h55, 0, 0,  1, 0, 9'h000, 8'hFC, 8'h00, 0);
    v(1, 0, 8'h00, 0, 0,  0, 1, 9'h020, 8'hFC, 8'h55, 0);
    v(1, 0, 8'h00, 1, 0,  0, 1, 9'h020, 8'hFC, 8'h55, 0);
    v(1, 0, 8'h00, 0, 0,  1, 0, 9'h000, 8'hFC, 8'h55, 0);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      clr_n = tbl[i].clr_n; dv = tbl[i].dv; d = tbl[i].d; ack = tbl[i].ack; res = tbl[i].res;
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 32'(rdy_a), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d valid", i), 32'(val_a), 32'(tbl[i].e_val));
      chk($sformatf("row%0d decode", i), 32'(dec_a), 32'(tbl[i].e_dec));
      chk($sformatf("row%0d opcode", i), 32'(opc_a), 32'(tbl[i].e_opc));
      chk($sformatf("row%0d operand", i), 32'(opnd_a), 32'(tbl[i].e_opnd));
      chk($sformatf("row%0d halted", i), 32'(hlt_a), 32'(tbl[i].e_hlt));
    end

    // Two-byte LD with a 2-cycle gap between operand bytes on the wide instance.
    @(posedge clk); #1; clr_n = 1'b0; dv = 1'b0; ack = 1'b0; res = 1'b0;
    @(posedge clk); #1; clr_n = 1'b1;
    @(posedge clk); #1; dv = 1'b1; d = 8'hFF;
    @(negedge clk); chk("ld2 ready at opcode", 32'(rdy_b), 32'd1);
    @(posedge clk); #1; d = 8'h34;
    @(posedge clk); #1; dv = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk("ld2 stalled ready", 32'(rdy_b), 32'd1);
    @(posedge clk); #1; dv = 1'b1; d = 8'h12;
    @(negedge clk); chk("ld2 not valid early", 32'(val_b), 32'd0);
    @(posedge clk); #1; dv = 1'b0;
    @(negedge clk);
    chk("ld2 valid", 32'(val_b), 32'd1);
    chk("ld2 decode", 32'(dec_b), 32'h100);
    chk("ld2 operand", 32'(opnd_b), 32'h1234);
    chk("ld2 opcode", 32'(opc_b), 32'hFF);

    repeat (3000) begin
      @(posedge clk); #1;
      clr_n = ($urandom_range(0, 99) != 0);
      dv    = ($urandom_range(0, 9) < 7);
      d     = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 8)] : 8'($urandom);
      ack   = ($urandom_range(0, 9) < 3);
      res   = ($urandom_range(0, 9) < 2);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ir_fetch_decode.md
Name: ir_fetch_decode

Overview:
- Parametrised successor to the model computer's single-byte instruction register.
- Accepts a byte stream from the memory data bus over a valid/ready handshake.
- Latches an opcode, then collects 0 or OPND_BYTES operand bytes depending on the opcode.
- Presents a one-hot decoded instruction with its operand until the controller acknowledges it, and holds a sticky halt state until resumed.

Parameters:
- DATA_W, 8, width of the data bus and of each operand byte (min 8).
- OPND_BYTES, 1, number of operand bytes fetched for operand-carrying opcodes (min 1).

Ports:
- CLK  in  1  clock, rising edge.
- CLR_N  in  1  asynchronous active-low reset.
- D  in  DATA_W  byte from the memory data bus.
- D_VALID  in  1  D holds a valid byte.
- D_READY  out  1  block accepts D this cycle. A transfer occurs when D_VALID and D_READY are both high at a rising edge.
- INSTR_ACK  in  1  controller consumes the presented instruction.
- RESUME  in  1  leave the halted state.
- INSTR_VALID  out  1  a decoded instruction is presented.
- LD, ADD, SUB, AND, OR, SHL, XOR, HALT, ILLEGAL  out  1 each  one-hot decode, gated by INSTR_VALID.
- OPCODE  out  DATA_W  latched opcode byte.
- OPERAND  out  OPND_BYTES*DATA_W  collected operand bytes, little-endian.
- HALTED  out  1  block is in the halt state.

Behaviour:
- Reset: CLK is the only clock. CLR_N is asynchronous and active-low.
  - While CLR_N is low: state=S_OPC, OPCODE=0, OPERAND=0, byte counter=0, and all outputs are 0, including D_READY.
  - Reset mid-fetch discards any partial instruction.
- Opcode encodings (opcode field = D[7:0]; any nonzero D[DATA_W-1:8] forces ILLEGAL):
  - LD=8'hFF, ADD=8'hFE, SUB=8'hFD, AND=8'hFC, OR=8'hFB, SHL=8'hF9, HALT=8'hF8, XOR=8'hF2.
  - Any other value decodes as ILLEGAL.
- Operand-carrying opcodes: LD, ADD, SUB, AND, OR, XOR. SHL, HALT and ILLEGAL carry none.
- FSM states S_OPC, S_OPND, S_HOLD, S_HALT:
  - S_OPC: D_READY=1. On transfer, OPCODE<=D and OPERAND<=0.
    - Operand-carrying opcode: counter<=0, go to S_OPND.
    - Otherwise: go to S_HOLD.
  - S_OPND: D_READY=1. On transfer, OPERAND[counter*DATA_W +: DATA_W]<=D and counter increments.
    - When counter==OPND_BYTES-1 at the transfer, go to S_HOLD.
    - Stalls indefinitely while D_VALID=0.
  - S_HOLD: INSTR_VALID=1, D_READY=0, decode lines active, OPCODE/OPERAND stable.
    - On INSTR_ACK: go to S_HALT if HALT, else S_OPC.
  - S_HALT: HALTED=1, D_READY=0, INSTR_VALID=0. On RESUME, go to S_OPC.
- Latency:
  - Non-operand instruction: INSTR_VALID is high in the cycle after the opcode transfer.
  - Operand instruction: INSTR_VALID is high in the cycle after the last operand transfer.
  - Best-case throughput: one instruction per (1 + operand bytes + 1) cycles.
- Decode lines are combinational from OPCODE AND INSTR_VALID. Exactly one is high when INSTR_VALID=1, and all are 0 otherwise.
- Boundary conditions:
  - INSTR_ACK outside S_HOLD is ignored.
  - RESUME outside S_HALT is ignored.
  - RESUME and INSTR_ACK in the same cycle act only on the current state.
  - D_VALID during S_HOLD or S_HALT is not consumed; the byte is taken once back in S_OPC.
  - ACK in S_HOLD with D_VALID high: the next opcode is accepted one cycle later, never the same cycle.
  - ILLEGAL is presented like any instruction; the controller must ACK it. No operands are fetched for it.
  - All registers are updated only on transfers or state changes; no X propagation from D when D_VALID=0.

Decomposition:
- Shared package ir_pkg holds:
  - opcode localparams OPC_LD..OPC_XOR;
  - the state enum/encoding for S_OPC..S_HALT;
  - function has_operand(opcode).
- One natural sub-module: ir_decode, the combinational opcode-to-one-hot decoder including ILLEGAL, reused by the future control unit.
- The FSM, counter and operand shift/insert logic stay in ir_fetch_decode.

Test Plan:
- Reset: hold CLR_N=0 with D_VALID=1, D=8'hFE -> D_READY=0, INSTR_VALID=0, OPCODE=0, all decode lines 0. Release -> D_READY=1 next cycle.
- ADD with operand (OPND_BYTES=1): send FE, then 3C back-to-back, hold INSTR_ACK=0 for 5 cycles -> INSTR_VALID stays 1 with ADD=1, OPERAND=8'h3C. ACK -> D_READY=1 next cycle.
- Two-byte operand (OPND_BYTES=2): send FF, 34, 12 with a 2-cycle D_VALID gap between 34 and 12 -> LD=1, OPERAND=16'h1234, INSTR_VALID one cycle after byte 12.
- No-operand and illegal: send F9 -> SHL=1, OPERAND=0, valid the cycle after the opcode. Send 8'h00 -> ILLEGAL=1, no operand fetched. ACK each -> back to S_OPC.
- Halt/resume: send F8, ACK -> HALTED=1, D_READY=0 while D_VALID=1 with D=FE held. RESUME -> FE accepted the next cycle, ADD decoded.
- Reset mid-fetch: send FD, assert CLR_N=0 before the operand -> all outputs 0. After release, send FC, 55 -> AND=1, OPERAND=8'h55, no residue from FD.
